// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared definitions for the data-cache miss controller.
//   state_e          : controller FSM encoding
//   OFF_*            : byte-offset-within-word constants
//   merge_misaligned : assembles a 32-bit load from two aligned words
package dcache_miss_ctrl_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_FILL,
    ST_RESP,
    ST_WR,
    ST_WDONE
  } state_e;

  localparam logic [1:0] OFF_ALIGNED = 2'd0;
  localparam logic [1:0] OFF_B1      = 2'd1;
  localparam logic [1:0] OFF_B2      = 2'd2;
  localparam logic [1:0] OFF_B3      = 2'd3;

  // Little-endian merge: low bytes come from the upper part of w0, high bytes from w1.
  function automatic logic [WORD_W-1:0] merge_misaligned(input logic [WORD_W-1:0] w0,
                                                         input logic [WORD_W-1:0] w1,
                                                         input logic [1:0]        off);
    logic [WORD_W-1:0] r;
    case (off)
      OFF_B1:  r = {w1[7:0],  w0[31:8]};
      OFF_B2:  r = {w1[15:0], w0[31:16]};
      OFF_B3:  r = {w1[23:0], w0[31:24]};
      default: r = w0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_perf_cnt.sv
// Pair of saturating performance counters (load hits / load misses).
//   clk, rst        : clock, async active-high reset
//   hit_inc_i       : increment hit counter this cycle
//   miss_inc_i      : increment miss counter this cycle
//   hit_cnt_o       : saturating hit count
//   miss_cnt_o      : saturating miss count
module dcache_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_inc_i,
  input  logic             miss_inc_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;

  // Counters stick at all-ones once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_inc_i && (hit_q != '1)) begin
        hit_q <= hit_q + CNT_W'(1);
      end
      if (miss_inc_i && (miss_q != '1)) begin
        miss_q <= miss_q + CNT_W'(1);
      end
    end
  end

  assign hit_cnt_o  = hit_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller between the MEM stage, the data cache and the memory bus.
// Handles zero-latency load hits, one/two-word refills for (mis)aligned load misses,
// write-through stores, and hit/miss performance counting.
//   MEM stage : mem_rd, mem_wr, mem_addr, mem_wdata -> stall, mem_rdata
//   cache     : dc_r_en/dc_r_addr, dc_hit/dc_r_data, dc_fill_en/dc_fill_addr,
//               dc_w_en/dc_w_addr/dc_w_data
//   bus       : bus_req/bus_we/bus_addr/bus_wdata -> bus_ack/bus_rdata
//   perf      : hit_cnt, miss_cnt
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              dc_r_en,
  output logic [ADDR_W-1:0] dc_r_addr,
  input  logic              dc_hit,
  input  logic [DATA_W-1:0] dc_r_data,
  output logic              dc_fill_en,
  output logic [ADDR_W-1:0] dc_fill_addr,
  output logic              dc_w_en,
  output logic [ADDR_W-1:0] dc_w_addr,
  output logic [DATA_W-1:0] dc_w_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] w0_q, w0_d;
  logic [DATA_W-1:0] w1_q, w1_d;
  // Forces the idle bus cycle between the two refill reads.
  logic              gap_q, gap_d;
  logic              hit_inc;
  logic              miss_inc;

  logic [1:0]        off;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic              need2;

  assign off   = mem_addr[1:0];
  assign a0    = {mem_addr[ADDR_W-1:2], 2'b00};
  assign a1    = a0 + ADDR_W'(4);
  assign need2 = (off != OFF_ALIGNED);

  // Address/data passthroughs; the MEM stage holds them for the whole access.
  assign dc_r_addr    = mem_addr;
  assign dc_fill_addr = mem_addr;
  assign dc_w_addr    = mem_addr;
  assign dc_w_data    = mem_wdata;
  assign bus_wdata    = mem_wdata;

  // State and refill buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    gap_d      = 1'b0;
    stall      = 1'b0;
    mem_rdata  = '0;
    dc_r_en    = 1'b0;
    dc_fill_en = 1'b0;
    dc_w_en    = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_wr) begin
          stall   = 1'b1;
          state_d = ST_WR;
        end else if (mem_rd) begin
          dc_r_en = 1'b1;
          if (dc_hit) begin
            mem_rdata = dc_r_data;
            hit_inc   = 1'b1;
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            state_d  = ST_RD0;
          end
        end
      end
      ST_RD0: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_addr = a0;
        if (bus_ack) begin
          w0_d = bus_rdata;
          if (need2) begin
            gap_d   = 1'b1;
            state_d = ST_RD1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_RD1: begin
        stall    = 1'b1;
        bus_addr = a1;
        if (!gap_q) begin
          bus_req = 1'b1;
          if (bus_ack) begin
            w1_d    = bus_rdata;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        stall      = 1'b1;
        dc_fill_en = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        mem_rdata = merge_misaligned(w0_q, w1_q, off);
        state_d   = ST_IDLE;
      end
      ST_WR: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        bus_addr = mem_addr;
        if (bus_ack) begin
          dc_w_en = 1'b1;
          state_d = ST_WDONE;
        end
      end
      ST_WDONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  dcache_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .hit_inc_i (hit_inc),
    .miss_inc_i(miss_inc),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl: scoreboard of expected load data and
// bus transactions, a bus responder with programmable latency, and a memory model.
module tb_dcache_miss_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall;
  logic [31:0] mem_rdata;
  logic        dc_r_en;
  logic [31:0] dc_r_addr;
  logic        dc_hit;
  logic [31:0] dc_r_data;
  logic        dc_fill_en;
  logic [31:0] dc_fill_addr;
  logic        dc_w_en;
  logic [31:0] dc_w_addr, dc_w_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  dcache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .mem_rdata(mem_rdata),
    .dc_r_en(dc_r_en), .dc_r_addr(dc_r_addr), .dc_hit(dc_hit), .dc_r_data(dc_r_data),
    .dc_fill_en(dc_fill_en), .dc_fill_addr(dc_fill_addr),
    .dc_w_en(dc_w_en), .dc_w_addr(dc_w_addr), .dc_w_data(dc_w_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  logic [31:0] exp_q[$];
  bus_t        exp_bus_q[$];
  logic [31:0] mem_m[logic [31:0]];

  int n_chk = 0;
  int n_err = 0;
  int fills = 0;
  int wens  = 0;
  int lat   = 0;
  int hit_m = 0;
  int miss_m = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [1:0] off);
    case (off)
      2'd1:    return {w1[7:0],  w0[31:8]};
      2'd2:    return {w1[15:0], w0[31:16]};
      2'd3:    return {w1[23:0], w0[31:24]};
      default: return w0;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  // Bus responder: acks after 'lat' requesting cycles, one-cycle ack.
  initial begin
    int cnt;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus_ack = 1'b0; cnt = 0;
      end else if (bus_ack) begin
        bus_ack = 1'b0; cnt = 0;
      end else if (bus_req) begin
        if (cnt >= lat) begin
          bus_ack   = 1'b1;
          bus_rdata = bus_we ? 32'h0 : mem_word(bus_addr);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: scoreboard pops for load data and bus transactions, strobe accounting.
  initial begin
    bit   prev_ack;
    bus_t b;
    logic [31:0] e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ack = 1'b0;
      end else begin
        if (prev_ack) chk("bus_gap", 32'(bus_req), 32'h0);
        prev_ack = bus_req && bus_ack;
        if (dc_fill_en) fills++;
        if (dc_w_en) wens++;
        if (bus_req && bus_ack) begin
          if (exp_bus_q.size() == 0) begin
            chk("bus_unexp", 32'(exp_bus_q.size()), 32'h1);
          end else begin
            b = exp_bus_q.pop_front();
            chk("bus_we", 32'(bus_we), 32'(b.we));
            chk("bus_addr", bus_addr, b.addr);
            chk("dc_w_en_ack", 32'(dc_w_en), 32'(b.we));
            if (b.we) begin
              chk("bus_wdata", bus_wdata, b.data);
              chk("dc_w_data", dc_w_data, b.data);
              chk("dc_w_addr", dc_w_addr, b.addr);
            end
          end
        end else begin
          chk("dc_w_en_stray", 32'(dc_w_en), 32'h0);
        end
        if (mem_rd && !mem_wr && !stall) begin
          if (exp_q.size() == 0) begin
            chk("rd_unexp", 32'(exp_q.size()), 32'h1);
          end else begin
            e = exp_q.pop_front();
            chk("mem_rdata", mem_rdata, e);
          end
        end
      end
    end
  end

  task automatic wait_nostall(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 32'(stall), 32'h0);
  endtask

  task automatic do_load(input logic [31:0] addr, input bit hit, input logic [31:0] hdata);
    logic [31:0] a0, a1;
    int   f0;
    bus_t b;
    @(posedge clk); #1;
    a0 = {addr[31:2], 2'b00};
    a1 = a0 + 32'd4;
    f0 = fills;
    if (hit) begin
      exp_q.push_back(hdata);
    end else begin
      exp_q.push_back(merge(mem_word(a0), mem_word(a1), addr[1:0]));
      b.we = 1'b0; b.addr = a0; b.data = '0;
      exp_bus_q.push_back(b);
      if (addr[1:0] != 2'd0) begin
        b.addr = a1;
        exp_bus_q.push_back(b);
      end
    end
    mem_addr  = addr;
    mem_rd    = 1'b1;
    dc_hit    = hit;
    dc_r_data = hit ? hdata : 32'h0BAD0BAD;
    #1;
    chk("dc_r_en", 32'(dc_r_en), 32'h1);
    chk("ld_stall0", 32'(stall), hit ? 32'h0 : 32'h1);
    wait_nostall("ld");
    if (hit) hit_m = sat(hit_m); else miss_m = sat(miss_m);
    @(posedge clk); #1;
    mem_rd = 1'b0;
    dc_hit = 1'b0;
    chk("hit_cnt", 32'(hit_cnt), 32'(hit_m));
    chk("miss_cnt", 32'(miss_cnt), 32'(miss_m));
    chk("fill_n", 32'(fills - f0), hit ? 32'h0 : 32'h1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit rd_too);
    int   w0;
    bus_t b;
    @(posedge clk); #1;
    w0 = wens;
    b.we = 1'b1; b.addr = addr; b.data = data;
    exp_bus_q.push_back(b);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wr    = 1'b1;
    mem_rd    = rd_too;
    dc_hit    = rd_too;
    dc_r_data = 32'h0BAD0BAD;
    #1;
    chk("wr_stall0", 32'(stall), 32'h1);
    wait_nostall("wr");
    chk("w_en_n", 32'(wens - w0), 32'h1);
    @(posedge clk); #1;
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    dc_hit = 1'b0;
    chk("wr_hit_cnt", 32'(hit_cnt), 32'(hit_m));
    chk("wr_miss_cnt", 32'(miss_cnt), 32'(miss_m));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int f0;
    rst = 1'b1;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    dc_hit = 1'b0; dc_r_data = '0;
    mem_m[32'h200] = 32'h11223344;
    mem_m[32'h300] = 32'hAABBCCDD;
    mem_m[32'h304] = 32'h55667788;

    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_fill", 32'(dc_fill_en), 32'h0);
    chk("rst_w_en", 32'(dc_w_en), 32'h0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'h0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load(32'h100, 1'b1, 32'hDEADBEEF);     // hit
    lat = 3;
    do_load(32'h200, 1'b0, 32'h0);            // aligned miss
    lat = 1;
    do_load(32'h302, 1'b0, 32'h0);            // misaligned miss
    chk("misaligned_const", merge(32'hAABBCCDD, 32'h55667788, 2'd2), 32'h7788AABB);
    lat = 2;
    do_store(32'h400, 32'hCAFEF00D, 1'b0);
    do_store(32'h403, 32'h12345678, 1'b1);    // store wins over load
    lat = 0;
    do_load(32'hFFFFFFFD, 1'b0, 32'h0);       // wrap to 0x0
    for (int i = 0; i < 13; i++) begin
      lat = i % 3;
      do_load(32'h500 + 32'(i * 5), 1'b0, 32'h0);
    end
    chk("miss_sat", 32'(miss_cnt), 32'(CNT_MAX));
    do_load(32'h104, 1'b1, 32'h01020304);

    // Reset while waiting in the second refill read.
    lat = 5;
    @(posedge clk); #1;
    mem_addr = 32'h702; mem_rd = 1'b1; dc_hit = 1'b0;
    begin
      bus_t b;
      b.we = 1'b0; b.addr = 32'h700; b.data = '0;
      exp_bus_q.push_back(b);
    end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus_req && bus_addr == 32'h704) found = 1'b1;
    end
    chk("rd1_reach", 32'(found), 32'h1);
    #2;
    f0 = fills;
    rst = 1'b1;
    mem_rd = 1'b0;
    #1;
    chk("arst_bus_req", 32'(bus_req), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_hit_cnt", 32'(hit_cnt), 32'h0);
    chk("arst_miss_cnt", 32'(miss_cnt), 32'h0);
    hit_m = 0;
    miss_m = 0;
    exp_q.delete();
    exp_bus_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_no_fill", 32'(fills - f0), 32'h0);
    chk("arst_idle_req", 32'(bus_req), 32'h0);
    do_load(32'h108, 1'b1, 32'h0F0F0F0F);

    chk("sb_rd_left", 32'(exp_q.size()), 32'h0);
    chk("sb_bus_left", 32'(exp_bus_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
